// File: rtl/dma_ctrl_regs.sv
// AXI4-Lite control/status register file for the loopback DMA (MM2S + S2MM channels).
// Optional interrupt logic (IOC_IrqEn, IOC_Irq, introut) is built only when DMA_CTRL_IRQ_EN is defined.

// state   | meaning
// HALTED  | RS=0 or after reset; Halted=1, LENGTH writes rejected
// IDLE    | running, no transfer; Idle=1, nonzero LENGTH write starts one
// CMD     | command presented to the mover, waiting for cmd_ready
// BUSY    | command accepted, waiting for the mover's done pulse
module dma_ctrl_chan #(
    parameter int LEN_W       = 14,
    parameter bit CAPTURE_LEN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cr_we,
    input  logic             sr_we,
    input  logic             sa_we,
    input  logic             len_we,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wstrb,
    output logic             len_err,
    output logic [31:0]      cr_val,
    output logic [31:0]      sr_val,
    output logic [31:0]      sa_val,
    output logic [31:0]      len_val,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [31:0]      cmd_addr,
    output logic [LEN_W-1:0] cmd_len,
    input  logic             done,
    input  logic [LEN_W-1:0] done_len,
    output logic             introut
);

    localparam logic [1:0] ST_HALTED = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_CMD    = 2'd2;
    localparam logic [1:0] ST_BUSY   = 2'd3;

    logic [1:0]       state;
    logic             rs;
    logic [31:0]      sa;
    logic [LEN_W-1:0] len;
    logic [31:0]      sa_new;
    logic [LEN_W-1:0] len_new;
    logic             len_ok;
    logic             ioc_en;
    logic             ioc_irq;

    function automatic logic [31:0] merge32(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  strb);
        merge32 = {strb[3] ? new_v[31:24] : old_v[31:24],
                   strb[2] ? new_v[23:16] : old_v[23:16],
                   strb[1] ? new_v[15:8]  : old_v[15:8],
                   strb[0] ? new_v[7:0]   : old_v[7:0]};
    endfunction

    assign sa_new  = merge32(sa, wdata, wstrb);
    assign len_new = LEN_W'(merge32({{(32-LEN_W){1'b0}}, len}, wdata, wstrb));
    // LENGTH is only writable while the channel is running and has nothing in flight.
    assign len_ok  = (state == ST_IDLE) && rs;
    assign len_err = !len_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_HALTED;
            rs       <= 1'b0;
            sa       <= '0;
            len      <= '0;
            cmd_addr <= '0;
            cmd_len  <= '0;
        end else begin
            if (cr_we)
                rs <= wdata[0];
            if (sa_we)
                sa <= sa_new;
            if (len_we && len_ok)
                len <= len_new;
            case (state)
                ST_HALTED: begin
                    if (rs)
                        state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (!rs) begin
                        state <= ST_HALTED;
                    end else if (len_we && (len_new != '0)) begin
                        state    <= ST_CMD;
                        cmd_addr <= sa;
                        cmd_len  <= len_new;
                    end
                end
                ST_CMD: begin
                    if (cmd_ready)
                        state <= ST_BUSY;
                end
                default: begin
                    if (done) begin
                        state <= rs ? ST_IDLE : ST_HALTED;
                        if (CAPTURE_LEN)
                            len <= done_len;
                    end
                end
            endcase
        end
    end

`ifdef DMA_CTRL_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ioc_en  <= 1'b0;
            ioc_irq <= 1'b0;
        end else begin
            if (cr_we)
                ioc_en <= wdata[12];
            // A completion on the same edge as the W1C wins.
            if (state == ST_BUSY && done)
                ioc_irq <= 1'b1;
            else if (sr_we && wdata[12])
                ioc_irq <= 1'b0;
        end
    end
`else
    assign ioc_en  = 1'b0;
    assign ioc_irq = 1'b0;
`endif

    assign cmd_valid = (state == ST_CMD);
    assign introut   = ioc_irq & ioc_en;
    assign cr_val    = {19'd0, ioc_en, 11'd0, rs};
    assign sr_val    = {19'd0, ioc_irq, 10'd0, (state == ST_IDLE), (state == ST_HALTED)};
    assign sa_val    = sa;
    assign len_val   = {{(32-LEN_W){1'b0}}, len};

endmodule

module dma_ctrl_regs #(
    parameter int ADDR_W = 7,
    parameter int LEN_W  = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic [31:0]       mm2s_cmd_addr,
    output logic [LEN_W-1:0]  mm2s_cmd_len,
    output logic              mm2s_cmd_valid,
    input  logic              mm2s_cmd_ready,
    input  logic              mm2s_done,
    output logic [31:0]       s2mm_cmd_addr,
    output logic [LEN_W-1:0]  s2mm_cmd_len,
    output logic              s2mm_cmd_valid,
    input  logic              s2mm_cmd_ready,
    input  logic              s2mm_done,
    input  logic [LEN_W-1:0]  s2mm_done_len,
    output logic              mm2s_introut,
    output logic              s2mm_introut
);

    localparam logic [ADDR_W-1:0] OFF_MM2S_CR  = ADDR_W'('h00);
    localparam logic [ADDR_W-1:0] OFF_MM2S_SR  = ADDR_W'('h04);
    localparam logic [ADDR_W-1:0] OFF_MM2S_SA  = ADDR_W'('h18);
    localparam logic [ADDR_W-1:0] OFF_MM2S_LEN = ADDR_W'('h28);
    localparam logic [ADDR_W-1:0] OFF_S2MM_CR  = ADDR_W'('h30);
    localparam logic [ADDR_W-1:0] OFF_S2MM_SR  = ADDR_W'('h34);
    localparam logic [ADDR_W-1:0] OFF_S2MM_DA  = ADDR_W'('h48);
    localparam logic [ADDR_W-1:0] OFF_S2MM_LEN = ADDR_W'('h58);

    logic        wr_rdy;
    logic        wr_hs;
    logic        ar_rdy;
    logic        strb_full;
    logic        mm2s_cr_we, mm2s_sr_we, mm2s_sa_we, mm2s_len_we;
    logic        s2mm_cr_we, s2mm_sr_we, s2mm_sa_we, s2mm_len_we;
    logic        mm2s_len_err, s2mm_len_err;
    logic        soft_rst;
    logic        chan_rst;
    logic [31:0] mm2s_cr, mm2s_sr, mm2s_sa, mm2s_len;
    logic [31:0] s2mm_cr, s2mm_sr, s2mm_sa, s2mm_len;
    logic [31:0] rd_mux;

    assign wr_hs     = wr_rdy && s_axi_awvalid && s_axi_wvalid;
    assign strb_full = (s_axi_wstrb == 4'hF);

    assign mm2s_cr_we  = wr_hs && strb_full && (s_axi_awaddr == OFF_MM2S_CR);
    assign mm2s_sr_we  = wr_hs && strb_full && (s_axi_awaddr == OFF_MM2S_SR);
    assign mm2s_sa_we  = wr_hs && (s_axi_awaddr == OFF_MM2S_SA);
    assign mm2s_len_we = wr_hs && (s_axi_awaddr == OFF_MM2S_LEN);
    assign s2mm_cr_we  = wr_hs && strb_full && (s_axi_awaddr == OFF_S2MM_CR);
    assign s2mm_sr_we  = wr_hs && strb_full && (s_axi_awaddr == OFF_S2MM_SR);
    assign s2mm_sa_we  = wr_hs && (s_axi_awaddr == OFF_S2MM_DA);
    assign s2mm_len_we = wr_hs && (s_axi_awaddr == OFF_S2MM_LEN);

    // DMACR.Reset from either channel clears both; the bus handshake itself is not reset.
    assign soft_rst = (mm2s_cr_we || s2mm_cr_we) && s_axi_wdata[2];
    assign chan_rst = rst || soft_rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_rdy       <= 1'b0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= 2'b00;
            ar_rdy       <= 1'b0;
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
        end else begin
            wr_rdy <= !wr_rdy && !s_axi_bvalid && s_axi_awvalid && s_axi_wvalid;
            if (wr_hs) begin
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= ((mm2s_len_we && mm2s_len_err) ||
                                 (s2mm_len_we && s2mm_len_err)) ? 2'b10 : 2'b00;
            end else if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end

            ar_rdy <= !ar_rdy && !s_axi_rvalid && s_axi_arvalid;
            if (ar_rdy && s_axi_arvalid) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_mux;
            end else if (s_axi_rvalid && s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

    assign s_axi_awready = wr_rdy;
    assign s_axi_wready  = wr_rdy;
    assign s_axi_arready = ar_rdy;
    assign s_axi_rresp   = 2'b00;

    always_comb begin
        rd_mux = '0;
        case (s_axi_araddr)
            OFF_MM2S_CR:  rd_mux = mm2s_cr;
            OFF_MM2S_SR:  rd_mux = mm2s_sr;
            OFF_MM2S_SA:  rd_mux = mm2s_sa;
            OFF_MM2S_LEN: rd_mux = mm2s_len;
            OFF_S2MM_CR:  rd_mux = s2mm_cr;
            OFF_S2MM_SR:  rd_mux = s2mm_sr;
            OFF_S2MM_DA:  rd_mux = s2mm_sa;
            OFF_S2MM_LEN: rd_mux = s2mm_len;
            default:      rd_mux = '0;
        endcase
    end

    dma_ctrl_chan #(.LEN_W(LEN_W), .CAPTURE_LEN(1'b0)) u_mm2s (
        .clk       (clk),
        .rst       (chan_rst),
        .cr_we     (mm2s_cr_we),
        .sr_we     (mm2s_sr_we),
        .sa_we     (mm2s_sa_we),
        .len_we    (mm2s_len_we),
        .wdata     (s_axi_wdata),
        .wstrb     (s_axi_wstrb),
        .len_err   (mm2s_len_err),
        .cr_val    (mm2s_cr),
        .sr_val    (mm2s_sr),
        .sa_val    (mm2s_sa),
        .len_val   (mm2s_len),
        .cmd_valid (mm2s_cmd_valid),
        .cmd_ready (mm2s_cmd_ready),
        .cmd_addr  (mm2s_cmd_addr),
        .cmd_len   (mm2s_cmd_len),
        .done      (mm2s_done),
        .done_len  ('0),
        .introut   (mm2s_introut)
    );

    dma_ctrl_chan #(.LEN_W(LEN_W), .CAPTURE_LEN(1'b1)) u_s2mm (
        .clk       (clk),
        .rst       (chan_rst),
        .cr_we     (s2mm_cr_we),
        .sr_we     (s2mm_sr_we),
        .sa_we     (s2mm_sa_we),
        .len_we    (s2mm_len_we),
        .wdata     (s_axi_wdata),
        .wstrb     (s_axi_wstrb),
        .len_err   (s2mm_len_err),
        .cr_val    (s2mm_cr),
        .sr_val    (s2mm_sr),
        .sa_val    (s2mm_sa),
        .len_val   (s2mm_len),
        .cmd_valid (s2mm_cmd_valid),
        .cmd_ready (s2mm_cmd_ready),
        .cmd_addr  (s2mm_cmd_addr),
        .cmd_len   (s2mm_cmd_len),
        .done      (s2mm_done),
        .done_len  (s2mm_done_len),
        .introut   (s2mm_introut)
    );

endmodule

// File: tb/tb_dma_ctrl_regs.sv
// Scoreboard bench for dma_ctrl_regs: directed register-map scenarios followed by random traffic,
// all responses checked against a per-channel behavioural model.
module tb_dma_ctrl_regs;

    localparam int ADDR_W = 7;
    localparam int LEN_W  = 14;
`ifdef DMA_CTRL_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] s_axi_awaddr;
    logic              s_axi_awvalid, s_axi_awready;
    logic [31:0]       s_axi_wdata;
    logic [3:0]        s_axi_wstrb;
    logic              s_axi_wvalid, s_axi_wready;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bvalid, s_axi_bready;
    logic [ADDR_W-1:0] s_axi_araddr;
    logic              s_axi_arvalid, s_axi_arready;
    logic [31:0]       s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rvalid, s_axi_rready;
    logic [31:0]       mm2s_cmd_addr, s2mm_cmd_addr;
    logic [LEN_W-1:0]  mm2s_cmd_len, s2mm_cmd_len;
    logic              mm2s_cmd_valid, mm2s_cmd_ready, mm2s_done;
    logic              s2mm_cmd_valid, s2mm_cmd_ready, s2mm_done;
    logic [LEN_W-1:0]  s2mm_done_len;
    logic              mm2s_introut, s2mm_introut;

    dma_ctrl_regs #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .mm2s_cmd_addr(mm2s_cmd_addr), .mm2s_cmd_len(mm2s_cmd_len), .mm2s_cmd_valid(mm2s_cmd_valid),
        .mm2s_cmd_ready(mm2s_cmd_ready), .mm2s_done(mm2s_done),
        .s2mm_cmd_addr(s2mm_cmd_addr), .s2mm_cmd_len(s2mm_cmd_len), .s2mm_cmd_valid(s2mm_cmd_valid),
        .s2mm_cmd_ready(s2mm_cmd_ready), .s2mm_done(s2mm_done), .s2mm_done_len(s2mm_done_len),
        .mm2s_introut(mm2s_introut), .s2mm_introut(s2mm_introut)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int hs_cyc = -10;

    always @(posedge clk) cyc++;

    // Behavioural model: per channel, "halted" and "transfer outstanding" flags plus register contents.
    bit               m_rs[2], m_ioc_en[2], m_ioc[2], m_halted[2], m_xfer[2];
    logic [31:0]      m_sa[2];
    logic [LEN_W-1:0] m_len[2];

    logic [1:0]  exp_b[$];
    logic [31:0] exp_r[$];
    logic [45:0] exp_cmd0[$];
    logic [45:0] exp_cmd1[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++)
            if (strb[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_rs[c] = 0; m_ioc_en[c] = 0; m_ioc[c] = 0; m_halted[c] = 1; m_xfer[c] = 0;
            m_sa[c] = '0; m_len[c] = '0;
        end
        exp_cmd0.delete();
        exp_cmd1.delete();
    endtask

    function automatic logic [31:0] model_read(input logic [ADDR_W-1:0] a);
        int c;
        c = (a >= 7'h30) ? 1 : 0;
        case (a)
            7'h00, 7'h30: return (32'(m_ioc_en[c]) << 12) | 32'(m_rs[c]);
            7'h04, 7'h34: return (32'(m_ioc[c]) << 12) |
                                 (32'(!m_halted[c] && !m_xfer[c]) << 1) | 32'(m_halted[c]);
            7'h18, 7'h48: return m_sa[c];
            7'h28, 7'h58: return 32'(m_len[c]);
            default:      return 32'h0;
        endcase
    endfunction

    task automatic model_write(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                               input logic [3:0] strb, output logic [1:0] resp);
        int c;
        logic [31:0] m;
        c = (a >= 7'h30) ? 1 : 0;
        resp = 2'b00;
        case (a)
            7'h00, 7'h30: if (strb == 4'hF) begin
                if (d[2]) begin
                    model_reset();
                end else begin
                    m_rs[c]     = d[0];
                    m_ioc_en[c] = IRQ && d[12];
                    if (m_rs[c] && m_halted[c]) m_halted[c] = 0;
                    if (!m_rs[c] && !m_xfer[c]) m_halted[c] = 1;
                end
            end
            7'h04, 7'h34: if (strb == 4'hF && d[12]) m_ioc[c] = 0;
            7'h18, 7'h48: m_sa[c] = merge(m_sa[c], d, strb);
            7'h28, 7'h58: begin
                if (!m_halted[c] && !m_xfer[c] && m_rs[c]) begin
                    m = merge(32'(m_len[c]), d, strb);
                    m_len[c] = m[LEN_W-1:0];
                    if (m_len[c] != 0) begin
                        m_xfer[c] = 1;
                        if (c == 0) exp_cmd0.push_back({m_sa[c], m_len[c]});
                        else        exp_cmd1.push_back({m_sa[c], m_len[c]});
                    end
                end else begin
                    resp = 2'b10;
                end
            end
            default: ;
        endcase
    endtask

    task automatic model_done(input int c, input logic [LEN_W-1:0] dl);
        if (m_xfer[c]) begin
            m_xfer[c] = 0;
            if (IRQ) m_ioc[c] = 1;
            if (c == 1) m_len[c] = dl;
            if (!m_rs[c]) m_halted[c] = 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write_raw(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] strb);
        int n;
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = strb;
        s_axi_awvalid = 1; s_axi_wvalid = 1;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (s_axi_awready) break;
            n++;
        end
        if (n >= 20) check("awready_timeout", 64'(s_axi_awready), 64'(1));
        @(posedge clk);
        #1;
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        n = 0;
        while (exp_b.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (exp_b.size() != 0) begin
            check("b_response_missing", 64'(exp_b.size()), 64'(0));
            exp_b.delete();
        end
        #1;
    endtask

    task automatic axi_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] strb);
        logic [1:0] r;
        model_write(a, d, strb, r);
        exp_b.push_back(r);
        axi_write_raw(a, d, strb);
    endtask

    task automatic axi_read_raw(input logic [ADDR_W-1:0] a, input logic [31:0] e);
        int n;
        exp_r.push_back(e);
        s_axi_araddr = a;
        s_axi_arvalid = 1;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (s_axi_arready) break;
            n++;
        end
        if (n >= 20) check("arready_timeout", 64'(s_axi_arready), 64'(1));
        @(posedge clk);
        #1;
        s_axi_arvalid = 0;
        n = 0;
        while (exp_r.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (exp_r.size() != 0) begin
            check("r_response_missing", 64'(exp_r.size()), 64'(0));
            exp_r.delete();
        end
        #1;
    endtask

    task automatic axi_read(input logic [ADDR_W-1:0] a);
        axi_read_raw(a, model_read(a));
    endtask

    task automatic wait_cmd(input int c);
        int n;
        n = 0;
        while (((c == 0) ? exp_cmd0.size() : exp_cmd1.size()) != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (c == 0 && exp_cmd0.size() != 0) begin
            check("mm2s_cmd_missing", 64'(exp_cmd0.size()), 64'(0));
            exp_cmd0.delete();
        end
        if (c == 1 && exp_cmd1.size() != 0) begin
            check("s2mm_cmd_missing", 64'(exp_cmd1.size()), 64'(0));
            exp_cmd1.delete();
        end
        step();
    endtask

    task automatic pulse_done(input int c, input logic [LEN_W-1:0] dl);
        model_done(c, dl);
        if (c == 0) mm2s_done = 1;
        else begin s2mm_done = 1; s2mm_done_len = dl; end
        step();
        mm2s_done = 0; s2mm_done = 0;
    endtask

    task automatic check_intr();
        @(negedge clk);
        check("mm2s_introut", 64'(mm2s_introut), 64'(m_ioc[0] && m_ioc_en[0]));
        check("s2mm_introut", 64'(s2mm_introut), 64'(m_ioc[1] && m_ioc_en[1]));
    endtask

    // Monitor: pops expected responses whenever the DUT completes a handshake.
    bit prev_v0 = 0, prev_v1 = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (s_axi_awready || s_axi_wready)
                check("aw_w_ready_pair", 64'(s_axi_awready), 64'(s_axi_wready));
            if (s_axi_awready && s_axi_awvalid && s_axi_wvalid)
                hs_cyc = cyc + 1;
            if (s_axi_bvalid && s_axi_bready) begin
                if (exp_b.size() == 0) check("unexpected_b", 64'(exp_b.size()), 64'(1));
                else check("bresp", 64'(s_axi_bresp), 64'(exp_b.pop_front()));
            end
            if (s_axi_rvalid && s_axi_rready) begin
                check("rresp", 64'(s_axi_rresp), 64'(0));
                if (exp_r.size() == 0) check("unexpected_r", 64'(exp_r.size()), 64'(1));
                else check("rdata", 64'(s_axi_rdata), 64'(exp_r.pop_front()));
            end
            if (mm2s_cmd_valid && !prev_v0) check("mm2s_cmd_latency", 64'(cyc), 64'(hs_cyc));
            if (s2mm_cmd_valid && !prev_v1) check("s2mm_cmd_latency", 64'(cyc), 64'(hs_cyc));
            if (mm2s_cmd_valid && mm2s_cmd_ready) begin
                if (exp_cmd0.size() == 0) check("unexpected_mm2s_cmd", 64'(exp_cmd0.size()), 64'(1));
                else check("mm2s_cmd", 64'({mm2s_cmd_addr, mm2s_cmd_len}), 64'(exp_cmd0.pop_front()));
            end
            if (s2mm_cmd_valid && s2mm_cmd_ready) begin
                if (exp_cmd1.size() == 0) check("unexpected_s2mm_cmd", 64'(exp_cmd1.size()), 64'(1));
                else check("s2mm_cmd", 64'({s2mm_cmd_addr, s2mm_cmd_len}), 64'(exp_cmd1.pop_front()));
            end
        end
        prev_v0 = mm2s_cmd_valid;
        prev_v1 = s2mm_cmd_valid;
    end

    initial begin
        s_axi_bready = 1; s_axi_rready = 1;
        forever begin
            @(posedge clk);
            #1;
            s_axi_bready = ($urandom_range(0, 3) != 0);
            s_axi_rready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [ADDR_W-1:0] ADDRS [10] = '{7'h00, 7'h04, 7'h18, 7'h28, 7'h30,
                                                 7'h34, 7'h48, 7'h58, 7'h10, 7'h7C};

    initial begin
        logic [31:0] e;
        rst = 1;
        s_axi_awaddr = '0; s_axi_awvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 0;
        s_axi_araddr = '0; s_axi_arvalid = 0;
        mm2s_cmd_ready = 1; s2mm_cmd_ready = 1; mm2s_done = 0; s2mm_done = 0; s2mm_done_len = '0;
        model_reset();
        repeat (3) step();
        rst = 0;
        @(negedge clk);
        check("rst_axi_outs", 64'({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
                                   s_axi_arready, s_axi_rvalid, s_axi_rresp}), 64'(0));
        check("rst_rdata", 64'(s_axi_rdata), 64'(0));
        check("rst_cmd_valid", 64'({mm2s_cmd_valid, s2mm_cmd_valid}), 64'(0));
        check("rst_mm2s_cmd", 64'({mm2s_cmd_addr, mm2s_cmd_len}), 64'(0));
        check("rst_s2mm_cmd", 64'({s2mm_cmd_addr, s2mm_cmd_len}), 64'(0));
        check("rst_introut", 64'({mm2s_introut, s2mm_introut}), 64'(0));
        step();
        axi_read(7'h04);
        axi_read(7'h34);

        // MM2S happy path
        axi_write(7'h18, 32'h0010_0000, 4'hF);
        axi_write(7'h00, 32'h0000_1001, 4'hF);
        axi_write(7'h28, 32'd16352, 4'hF);
        wait_cmd(0);
        pulse_done(0, '0);
        axi_read(7'h04);
        check_intr();
        axi_write(7'h04, 32'h0000_1000, 4'hF);
        axi_read(7'h04);
        check_intr();

        // S2MM short packet
        axi_write(7'h30, 32'h0000_1001, 4'hF);
        axi_write(7'h48, 32'h0010_4000, 4'hF);
        axi_write(7'h58, 32'd16352, 4'hF);
        wait_cmd(1);
        pulse_done(1, 14'd4000);
        axi_read(7'h58);
        axi_read(7'h34);

        // LENGTH write while BUSY is refused
        axi_write(7'h28, 32'd100, 4'hF);
        wait_cmd(0);
        axi_write(7'h28, 32'd200, 4'hF);
        repeat (3) step();
        axi_read(7'h28);
        pulse_done(0, '0);

        // RS cleared mid-transfer: completes, then halts
        axi_write(7'h28, 32'd64, 4'hF);
        wait_cmd(0);
        axi_write(7'h00, 32'h0, 4'hF);
        axi_read(7'h00);
        pulse_done(0, '0);
        axi_read(7'h04);

        // Soft reset with both commands pending
        mm2s_cmd_ready = 0; s2mm_cmd_ready = 0;
        axi_write(7'h00, 32'h0000_1001, 4'hF);
        axi_write(7'h28, 32'd50, 4'hF);
        axi_write(7'h58, 32'd60, 4'hF);
        @(negedge clk);
        check("pending_cmd_valid", 64'({mm2s_cmd_valid, s2mm_cmd_valid}), 64'(2'b11));
        axi_write(7'h00, 32'h0000_0004, 4'hF);
        @(negedge clk);
        check("soft_rst_cmd_valid", 64'({mm2s_cmd_valid, s2mm_cmd_valid}), 64'(0));
        step();
        mm2s_cmd_ready = 1; s2mm_cmd_ready = 1;
        axi_read(7'h04);
        axi_read(7'h34);
        axi_read(7'h58);

        // Narrow strobes and concurrent read/write of the same register
        axi_write(7'h18, 32'hA5A5_A5A5, 4'hF);
        axi_write(7'h18, 32'h1234_5678, 4'b0101);
        axi_write(7'h00, 32'h0000_1001, 4'h3);
        axi_read(7'h18);
        axi_read(7'h00);
        e = model_read(7'h18);
        fork
            axi_read_raw(7'h18, e);
            axi_write(7'h18, 32'hDEAD_BEEF, 4'hF);
        join
        axi_read(7'h18);

        // Random traffic
        for (int it = 0; it < 300; it++) begin
            int op, c;
            logic [ADDR_W-1:0] a;
            logic [31:0] d;
            logic [3:0] s;
            op = $urandom_range(0, 9);
            a = ADDRS[$urandom_range(0, 9)];
            s = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
            if (op <= 5) begin
                d = $urandom;
                if (a == 7'h00 || a == 7'h30) begin
                    d = (d & 32'h1001) | (($urandom_range(0, 11) == 0) ? 32'h4 : 32'h0);
                    if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
                end else if (a == 7'h28 || a == 7'h58) begin
                    d = ($urandom_range(0, 3) == 0) ? 32'h0 : (d & 32'hFFFF);
                end
                axi_write(a, d, s);
            end else if (op <= 7) begin
                axi_read(a);
            end else begin
                c = $urandom_range(0, 1);
                if (m_xfer[c]) wait_cmd(c);
                pulse_done(c, 14'($urandom));
            end
            check_intr();
        end

        repeat (5) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
